// File: rtl/dma_count_reg.sv
`default_nettype none
// ============================================================================
// Module   : dma_count_reg
// Purpose  : Counting register for the Am2940 DMA datapath. Holds a
//            programmable initial value next to a working counter that steps
//            up or down once per enabled cycle. The counter can be reloaded
//            from the initial value without a bus write. Terminal-count and
//            sticky wrap flags feed the DMA done logic.
// Ports    : clk     - system clock, rising edge
//            rst_n   - asynchronous active-low reset
//            di      - parallel load data (WIDTH)
//            plwr    - parallel load strobe (writes initial reg and counter)
//            reinit  - copy initial register into working counter
//            cnt_en  - count enable, one step per cycle
//            cnt_up  - direction, 1 = up, 0 = down
//            cnt_q   - working counter (registered)
//            init_q  - initial register (registered)
//            tc      - terminal count (combinational)
//            wrap    - sticky wrap flag (registered)
// Revision : 1.0 - initial release
// ============================================================================
module dma_count_reg #(
   parameter int          WIDTH     = 8,
   parameter int unsigned RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] di,
   input  logic             plwr,
   input  logic             reinit,
   input  logic             cnt_en,
   input  logic             cnt_up,
   output logic [WIDTH-1:0] cnt_q,
   output logic [WIDTH-1:0] init_q,
   output logic             tc,
   output logic             wrap
);

   // Reset value truncated to the register width.
   localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);
   localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_init;
   logic             r_wrap;

   logic             w_all_ones;
   logic             w_zero;

   assign w_all_ones = &r_cnt;
   assign w_zero     = ~|r_cnt;

   // tc anticipates the wrap: the next enabled step in the current direction
   // would cross the all-ones/zero boundary. It ignores cnt_en on purpose.
   assign tc = cnt_up ? w_all_ones : w_zero;

   // Command priority: plwr > reinit > cnt_en > hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= c_reset_val;
         r_init <= c_reset_val;
         r_wrap <= 1'b0;
      end else if (plwr) begin
         r_cnt  <= di;
         r_init <= di;
         r_wrap <= 1'b0;
      end else if (reinit) begin
         r_cnt  <= r_init;
         r_wrap <= 1'b0;
      end else if (cnt_en) begin
         if (cnt_up) begin
            r_cnt <= r_cnt + c_one;
            if (w_all_ones) begin
               r_wrap <= 1'b1;
            end
         end else begin
            r_cnt <= r_cnt - c_one;
            if (w_zero) begin
               r_wrap <= 1'b1;
            end
         end
      end
   end

   assign cnt_q  = r_cnt;
   assign init_q = r_init;
   assign wrap   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_dma_count_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_count_reg
// Purpose  : Self-checking bench for dma_count_reg. Three instances:
//            A (WIDTH=8, RESET_VAL=00) runs the vector table,
//            B (WIDTH=8, RESET_VAL=A5) covers asynchronous reset mid-count,
//            C (WIDTH=1) covers the single-bit toggle case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_count_reg;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // ---------------- instance A ----------------
   logic       a_rst_n, a_plwr, a_reinit, a_en, a_up, a_tc, a_wrap;
   logic [7:0] a_di, a_cnt, a_init;

   dma_count_reg #(.WIDTH(8), .RESET_VAL(0)) u_dut_a (
      .clk(clk), .rst_n(a_rst_n), .di(a_di), .plwr(a_plwr), .reinit(a_reinit),
      .cnt_en(a_en), .cnt_up(a_up), .cnt_q(a_cnt), .init_q(a_init),
      .tc(a_tc), .wrap(a_wrap)
   );

   // ---------------- instance B ----------------
   logic       b_rst_n, b_plwr, b_reinit, b_en, b_up, b_tc, b_wrap;
   logic [7:0] b_di, b_cnt, b_init;

   dma_count_reg #(.WIDTH(8), .RESET_VAL(32'hA5)) u_dut_b (
      .clk(clk), .rst_n(b_rst_n), .di(b_di), .plwr(b_plwr), .reinit(b_reinit),
      .cnt_en(b_en), .cnt_up(b_up), .cnt_q(b_cnt), .init_q(b_init),
      .tc(b_tc), .wrap(b_wrap)
   );

   // ---------------- instance C ----------------
   logic c_rst_n, c_plwr, c_reinit, c_en, c_up, c_tc, c_wrap;
   logic c_di, c_cnt, c_init;

   dma_count_reg #(.WIDTH(1), .RESET_VAL(0)) u_dut_c (
      .clk(clk), .rst_n(c_rst_n), .di(c_di), .plwr(c_plwr), .reinit(c_reinit),
      .cnt_en(c_en), .cnt_up(c_up), .cnt_q(c_cnt), .init_q(c_init),
      .tc(c_tc), .wrap(c_wrap)
   );

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       plwr;
      logic       reinit;
      logic       en;
      logic       up;
      logic [7:0] di;
      logic [7:0] exp_cnt;
      logic [7:0] exp_init;
      logic       exp_wrap;
      logic       exp_tc;   // tc after the edge, with this vector's cnt_up held
   } vec_t;

   typedef struct {
      int         idx;
      logic [7:0] cnt;
      logic [7:0] init;
      logic       wrap;
      logic       tc;
   } exp_t;

   vec_t vecs[19];
   exp_t sb_q[$];

   initial begin
      exp_t e;

      //          plwr reinit en up  di     cnt    init   wrap tc
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h3C, 8'h3C, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hFE, 8'hFE, 8'hFE, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'hFF, 8'hFE, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFE, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 8'hFE, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01, 8'hFE, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 8'h02, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 8'h02, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h02, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'h02, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFE, 8'h02, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 8'h02, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h56, 8'h55, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h55, 8'h55, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1};
      vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 1'b1, 1'b0};

      a_rst_n = 1'b0; a_plwr = 1'b0; a_reinit = 1'b0; a_en = 1'b0; a_up = 1'b0; a_di = 8'h00;
      b_rst_n = 1'b0; b_plwr = 1'b0; b_reinit = 1'b0; b_en = 1'b0; b_up = 1'b0; b_di = 8'h00;
      c_rst_n = 1'b0; c_plwr = 1'b0; c_reinit = 1'b0; c_en = 1'b0; c_up = 1'b0; c_di = 1'b0;

      // ---- reset state ----
      repeat (2) @(posedge clk);
      #1;
      check("a_rst_cnt",  a_cnt,  8'h00);
      check("a_rst_init", a_init, 8'h00);
      check("a_rst_wrap", {7'd0, a_wrap}, 8'h00);
      check("b_rst_cnt",  b_cnt,  8'hA5);
      check("b_rst_init", b_init, 8'hA5);
      @(negedge clk);
      a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

      // ---- table-driven vectors on instance A, via scoreboard ----
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         a_plwr   = vecs[i].plwr;
         a_reinit = vecs[i].reinit;
         a_en     = vecs[i].en;
         a_up     = vecs[i].up;
         a_di     = vecs[i].di;
         sb_q.push_back('{i, vecs[i].exp_cnt, vecs[i].exp_init, vecs[i].exp_wrap, vecs[i].exp_tc});
         @(posedge clk);
         #1;
         if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_empty: got 0 entries expected 1");
         end else begin
            e = sb_q.pop_front();
            check($sformatf("v%0d_cnt", e.idx),  a_cnt,  e.cnt);
            check($sformatf("v%0d_init", e.idx), a_init, e.init);
            check($sformatf("v%0d_wrap", e.idx), {7'd0, a_wrap}, {7'd0, e.wrap});
            check($sformatf("v%0d_tc", e.idx),   {7'd0, a_tc},   {7'd0, e.tc});
         end
      end

      // ---- direction flip at terminal value ----
      @(negedge clk);
      a_plwr = 1'b1; a_reinit = 1'b0; a_en = 1'b0; a_up = 1'b0; a_di = 8'h00;
      @(negedge clk);
      a_plwr = 1'b0;
      #1;
      check("flip_tc_down", {7'd0, a_tc}, 8'h01);
      a_up = 1'b1;
      #1;
      check("flip_tc_up",   {7'd0, a_tc}, 8'h00);
      check("flip_hold",    a_cnt,        8'h00);

      // ---- asynchronous reset mid-count on instance B ----
      @(negedge clk);
      b_plwr = 1'b1; b_di = 8'h10; b_up = 1'b1;
      @(negedge clk);
      b_plwr = 1'b0; b_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("b_pre_rst_cnt", b_cnt, 8'h12);
      b_rst_n = 1'b0;
      #1;
      check("b_async_cnt",  b_cnt,  8'hA5);
      check("b_async_init", b_init, 8'hA5);
      check("b_async_wrap", {7'd0, b_wrap}, 8'h00);
      #1;
      b_rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("b_resume_1", b_cnt, 8'hA6);
      @(posedge clk);
      #1;
      check("b_resume_2", b_cnt, 8'hA7);
      b_en = 1'b0;

      // ---- WIDTH = 1 toggle and wrap ----
      @(negedge clk);
      c_up = 1'b1;
      #1;
      check("c_tc_at0_up", {7'd0, c_tc}, 8'h00);
      c_en = 1'b1;
      @(posedge clk);
      #1;
      check("c_step1_cnt",  {7'd0, c_cnt},  8'h01);
      check("c_step1_tc",   {7'd0, c_tc},   8'h01);
      check("c_step1_wrap", {7'd0, c_wrap}, 8'h00);
      @(posedge clk);
      #1;
      check("c_step2_cnt",  {7'd0, c_cnt},  8'h00);
      check("c_step2_wrap", {7'd0, c_wrap}, 8'h01);
      c_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/dma_count_reg.md
# dma_count_reg

Parametrised counting register for the Am2940 DMA generator datapath. It keeps a programmable initial value alongside a working counter. The working counter counts up or down one step per enabled cycle and can be reloaded from the initial value without a bus write. Address and word-count channels are built from instances of this block, and the wrap flags drive the DMA done logic.

## Interface
Parameters:
- WIDTH, 8, bit width of the initial register, the working counter and the data input.
- RESET_VAL, 0, value of both registers after reset; truncated to WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- di  input  WIDTH  parallel load data.
- plwr  input  1  parallel load strobe; writes di into both the initial register and the working counter.
- reinit  input  1  copies the initial register into the working counter.
- cnt_en  input  1  count enable; one step per cycle while high.
- cnt_up  input  1  direction: 1 = increment, 0 = decrement; sampled only when cnt_en is high.
- cnt_q  output  WIDTH  working counter value (registered).
- init_q  output  WIDTH  initial register value (registered).
- tc  output  1  terminal count; combinational from cnt_q and cnt_up.
- wrap  output  1  sticky wrap flag (registered).

## Operation
- Reset (rst_n low, asynchronous assert):
  - cnt_q = RESET_VAL, init_q = RESET_VAL, wrap = 0.
  - Release is synchronous to clk by the system reset synchroniser.
- Command priority per clock edge: plwr > reinit > cnt_en > hold.
- plwr: init_q <= di, cnt_q <= di, wrap <= 0. reinit and cnt_en are ignored that cycle.
- reinit (plwr low): cnt_q <= init_q, wrap <= 0, init_q unchanged. cnt_en is ignored.
- cnt_en, no load or reinit:
  - cnt_up=1: cnt_q <= cnt_q + 1, modulo 2^WIDTH.
  - cnt_up=0: cnt_q <= cnt_q - 1, modulo 2^WIDTH.
  - init_q unchanged.
- Wrap detection:
  - A step from all-ones to 0 (up) or from 0 to all-ones (down) sets wrap <= 1.
  - wrap stays set through further counting. Only plwr, reinit or reset clear it.
- tc = 1 when cnt_up=1 and cnt_q = all-ones, or when cnt_up=0 and cnt_q = 0. Otherwise tc = 0.
- tc is independent of cnt_en. It indicates that the next enabled step will wrap.
- Idle (no command): all registers hold.
- Arithmetic is unsigned, WIDTH bits. No saturation mode and no carry output beyond tc/wrap.

## Timing
- Load latency: di is visible on cnt_q and init_q one cycle after the plwr edge.
- Reinit latency: one cycle.
- Count latency: one cycle per step. Back-to-back steps are allowed every cycle.
- A direction change takes effect on the same edge that samples it. tc follows cnt_up combinationally within the cycle.
- wrap is set on the same edge that performs the wrapping step, so it is visible one cycle after tc was high with cnt_en.
- Reset asserted mid-count forces the reset values immediately, without waiting for clk. No partial update survives.
- WIDTH = 1 is legal: the counter toggles on every step, and tc/wrap follow the same rules.

## Test plan
- Reset and load (WIDTH=8, RESET_VAL=8'h00):
  - Assert rst_n=0 → cnt_q=00, init_q=00, wrap=0.
  - Release, then plwr with di=8'h3C → next cycle cnt_q=3C, init_q=3C.
- Up-count wrap:
  - Load 8'hFE, then cnt_en=1, cnt_up=1 for 3 cycles → cnt_q = FF, 00, 01.
  - tc=1 while cnt_q=FF; wrap becomes 1 when cnt_q=00 and stays 1.
- Down-count and reinit:
  - Load 8'h02, count down 3 cycles → cnt_q = 01, 00, FF, with wrap=1 after FF.
  - Pulse reinit → cnt_q=02, wrap=0, init_q=02.
- Priority:
  - plwr=1 (di=8'h55), reinit=1 and cnt_en=1 in the same cycle → cnt_q=55, init_q=55.
  - Then reinit=1 with cnt_en=1 → cnt_q=55 (no step taken).
- Asynchronous reset mid-operation:
  - Counting up from 8'h10 with RESET_VAL=8'hA5, drop rst_n between clock edges → cnt_q=A5, init_q=A5, wrap=0 before the next edge.
  - Counting resumes from A5 after release.
- Direction flip at terminal value: with cnt_q=00 and cnt_up=0, tc=1; switch cnt_up=1 → tc=0 in the same cycle.
